// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: one-entry holding register feeding a baud-tick-paced shifter.
// Optional parity bit when UART_TX_PARITY_EN is defined (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if ((DATA_BITS < 5) || (DATA_BITS > 8) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   hold_q;
  logic                   hold_full_q;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   load;
  logic                   accept;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // Handshake: a byte transfers on a posedge where tx_valid & tx_ready; tx_ready
  // is the registered "holding register empty" flag, independent of tx_valid.
  assign tx_ready = ~hold_full_q;
  assign accept   = tx_valid & ~hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
            tx_d       = parity_q;
`else
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
`endif
        STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            done_d = 1'b1;
            // A queued byte starts on this same tick so frames abut with no idle gap.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    if (load) shift_d = hold_q;
`ifdef UART_TX_PARITY_EN
    parity_d = load ? ((^hold_q) ^ (PARITY_ODD != 0)) : parity_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      // load needs a full register and accept an empty one, so they never coincide.
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q <= 1'b1;
        hold_q      <= tx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames at bit midpoints and the
// main sequence compares them, plus handshake/timing observations, against expectations.
module tb_uart_tx;

  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB         = 1 + 8 + PB + STOP_BITS;
  localparam int FRAME_CLKS = 16 * NB;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(STOP_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // ---------------- clock / reset / baud tick ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int div = 0;
  initial clk_en = 1'b0;
  always @(negedge clk) begin
    div    = (div == 15) ? 0 : div + 1;
    clk_en = (div == 15);
  end

  // ---------------- line monitor ----------------
  logic [11:0] obs_bits_q[$];
  int unsigned obs_start_q[$];
  int unsigned done_cyc_q[$];
  int          done_cnt = 0;
  bit          mon_active = 1'b0;
  int          mon_pos = 0;
  logic [11:0] mon_bits = '0;
  int unsigned mon_start = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_bits   = '0;
        mon_start  = cyc;
      end
    end else begin
      mon_pos++;
      if (mon_pos % 16 == 8) begin
        mon_bits[mon_pos / 16] = tx;
        if (mon_pos / 16 == NB - 1) begin
          obs_bits_q.push_back(mon_bits);
          obs_start_q.push_back(mon_start);
          mon_active = 1'b0;
        end
      end
    end
    if (rst_n === 1'b1 && tx_done === 1'b1) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          obs_idx = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [11:0] exp_frame(input logic [7:0] b);
    logic [11:0] f;
    f      = '0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^b) ^ (PARITY_ODD != 0);
`endif
    for (int i = 0; i < STOP_BITS; i++) f[9 + PB + i] = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input string tag);
    while (exp_q.size() > 0) begin
      check(tag, 32'(obs_bits_q[obs_idx]), 32'(exp_q.pop_front()));
      obs_idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, output int unsigned acc_cyc);
    int t = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 1000), 32'd1);
    @(negedge clk);
    acc_cyc  = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
  endtask

  task automatic wait_tick();
    int t = 0;
    @(posedge clk);
    while (clk_en !== 1'b1 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (obs_bits_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("frame_timeout", 32'(obs_bits_q.size() >= n), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int unsigned acc, acc3;
  int          frames_before, done_before;

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;

    // Single byte offered just after a tick: waits for the next one.
    wait_tick();
    exp_q.push_back(exp_frame(8'h55));
    send_byte(8'h55, acc);
    check("t1_ready_low", 32'(tx_ready), 32'd0);
    check("t1_line_idle", 32'(tx), 32'd1);
    check("t1_busy_idle", 32'(tx_busy), 32'd0);
    wait_tick();
    check("t1_start_bit", 32'(tx), 32'd0);
    check("t1_ready_back", 32'(tx_ready), 32'd1);
    check("t1_busy", 32'(tx_busy), 32'd1);
    wait_frames(1);
    score("t1_frame");
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_time", done_cyc_q[0] - obs_start_q[0], 32'(FRAME_CLKS));
    check("t1_busy_after", 32'(tx_busy), 32'd0);
    check("t1_line_after", 32'(tx), 32'd1);

    // Back-to-back, data changed after handshake, and a third byte behind a full holder.
    exp_q.push_back(exp_frame(8'h55));
    exp_q.push_back(exp_frame(8'hA3));
    exp_q.push_back(exp_frame(8'h3C));
    send_byte(8'h55, acc);
    send_byte(8'hA3, acc);
    check("t2_hold_full", 32'(tx_ready), 32'd0);
    send_byte(8'h3C, acc3);
    wait_frames(4);
    score("t2_frame");
    check("t2_gap_1_2", obs_start_q[2] - obs_start_q[1], 32'(FRAME_CLKS));
    check("t2_gap_2_3", obs_start_q[3] - obs_start_q[2], 32'(FRAME_CLKS));
    check("t3_accept_after_load", acc3 - obs_start_q[2], 32'd1);
    check("t2_done_cnt", 32'(done_cnt), 32'd4);
    check("t2_done_time", done_cyc_q[3] - obs_start_q[3], 32'(FRAME_CLKS));

    // Reset in the middle of the data bits with another byte held.
    send_byte(8'h0F, acc);
    send_byte(8'h77, acc);
    repeat (40) @(negedge clk);
    check("t5_busy_pre", 32'(tx_busy), 32'd1);
    frames_before = obs_bits_q.size();
    done_before   = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t5_tx_high", 32'(tx), 32'd1);
    check("t5_busy_low", 32'(tx_busy), 32'd0);
    check("t5_ready_high", 32'(tx_ready), 32'd1);
    check("t5_done_low", 32'(tx_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("t5_no_frame", 32'(obs_bits_q.size()), 32'(frames_before));
    check("t5_no_done", 32'(done_cnt), 32'(done_before));
    check("t5_line_idle", 32'(tx), 32'd1);

    exp_q.push_back(exp_frame(8'hC6));
    send_byte(8'hC6, acc);
    wait_frames(frames_before + 1);
    score("t5_post_reset_frame");
    check("t5_post_done_cnt", 32'(done_cnt), 32'(done_before + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
